// File: rtl/csam_product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : csam_product_accumulator
// Purpose  : Accumulates multiplier products into a dot-product frame result
//            presented on a valid/ready port.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module csam_product_accumulator #(
  parameter int PROD_W = 28,
  parameter int ACC_W  = 36,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_ovf;

  logic               w_accept;
  logic [ACC_W:0]     w_sum;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_ovf_nxt;

  assign in_ready  = (r_state == ST_ACCUM);
  assign w_accept  = in_valid && in_ready;

  // Extra top bit of the sum is the carry out of the accumulator width.
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(product);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ovf_nxt = r_ovf | w_sum[ACC_W];

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (!clear && w_accept && in_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_state == ST_ACCUM) begin
      if (clear) begin
        // Abort drops the partial frame and any beat offered this cycle.
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_accept) begin
        if (in_last) begin
          r_out_sum   <= w_sum[ACC_W-1:0];
          r_out_count <= w_cnt_inc;
          r_out_ovf   <= w_ovf_nxt;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
          r_cnt <= w_cnt_inc;
          r_ovf <= w_ovf_nxt;
        end
      end
    end else if (out_ready) begin
      // Result registers keep their values after the handshake.
      r_out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csam_product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_csam_product_accumulator
// Purpose  : Self-checking bench; a 36-bit and a 30-bit accumulator share
//            stimulus and are compared against a frame-level arithmetic model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_csam_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [27:0] product;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  in_ready_b;
  logic        out_valid, out_valid_b;
  logic [35:0] out_sum;
  logic [29:0] out_sum_b;
  logic [7:0]  out_count, out_count_b;
  logic        out_ovf,   out_ovf_b;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned terms[$];

  always #5 clk = ~clk;

  csam_product_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  csam_product_accumulator #(.ACC_W(30)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .product   (product),
    .in_last   (in_last),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_sum   (out_sum_b),
    .out_count (out_count_b),
    .out_ovf   (out_ovf_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame result straight from arithmetic: total of all terms, truncated.
  task automatic model(input int accw, output logic [63:0] s, output logic [63:0] ovf,
                       output logic [63:0] cnt);
    longint unsigned tot;
    tot = 0;
    foreach (terms[i]) tot += terms[i];
    s   = tot & ((64'd1 << accw) - 64'd1);
    ovf = ((tot >> accw) != 0) ? 64'd1 : 64'd0;
    cnt = (terms.size() > 255) ? 64'd255 : 64'(terms.size());
  endtask

  task automatic send_beat(input longint unsigned p, input logic last);
    int t;
    in_valid = 1'b1;
    product  = 28'(p);
    in_last  = last;
    t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (t == 50) check("accept_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < terms.size(); i++) begin
      repeat ($urandom_range(0, max_gap)) step();
      send_beat(terms[i], i == terms.size() - 1);
    end
  endtask

  task automatic check_result(input string tag);
    logic [63:0] s, o, c;
    model(36, s, o, c);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"},   64'(out_sum),   s);
    check({tag, "_count"}, 64'(out_count), c);
    check({tag, "_ovf"},   64'(out_ovf),   o);
    model(30, s, o, c);
    check({tag, "_valid_b"}, 64'(out_valid_b), 64'd1);
    check({tag, "_sum_b"},   64'(out_sum_b),   s);
    check({tag, "_ovf_b"},   64'(out_ovf_b),   o);
  endtask

  task automatic handshake(input int wait_cycles);
    logic [35:0] held;
    held = out_sum;
    repeat (wait_cycles) begin
      step();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum",   64'(out_sum),   64'(held));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_valid_drop", 64'(out_valid), 64'd0);
    check("hs_sum_kept",   64'(out_sum),   64'(held));
    check("hs_in_ready",   64'(in_ready),  64'd1);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; product = '0;
    in_last = 1'b0; out_ready = 1'b0;

    repeat (3) begin
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum",   64'(out_sum),   64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_out_ovf",   64'(out_ovf),   64'd0);
    end
    reset = 1'b1;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Four full-scale products.
    terms = {28'hFFEF001, 28'hFFEF001, 28'hFFEF001, 28'hFFEF001};
    send_frame(0);
    check_result("max4");
    check("max4_sum_const", 64'(out_sum), 64'h3FFBC004);
    handshake(0);

    // Backpressure: beats offered during HOLD must be ignored.
    terms = {28'h10, 28'h20, 28'h30};
    send_frame(0);
    check_result("bp");
    in_valid = 1'b1; product = 28'hABC; in_last = 1'b1;
    repeat (5) begin
      step();
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_sum",      64'(out_sum),   64'h60);
      check("bp_count",    64'(out_count), 64'd3);
      check("bp_in_ready", 64'(in_ready),  64'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake(0);
    terms = {28'h7};
    send_frame(0);
    check_result("single");
    check("single_sum_const", 64'(out_sum), 64'h7);
    handshake(1);

    // Five full-scale terms wrap the 30-bit instance.
    terms = {28'hFFEF001, 28'hFFEF001, 28'hFFEF001, 28'hFFEF001, 28'hFFEF001};
    send_frame(1);
    check_result("wrap5");
    check("wrap5_sum_b_const", 64'(out_sum_b), 64'h0FFAB005);
    check("wrap5_ovf_b_const", 64'(out_ovf_b), 64'd1);
    handshake(0);
    terms = {28'h1};
    send_frame(0);
    check_result("after_wrap");
    check("after_wrap_ovf_b", 64'(out_ovf_b), 64'd0);
    handshake(0);

    // Count saturation.
    terms.delete();
    repeat (300) terms.push_back(64'd1);
    send_frame(0);
    check_result("sat");
    check("sat_count_const", 64'(out_count), 64'd255);
    check("sat_sum_const",   64'(out_sum),   64'h12C);
    handshake(0);

    // Clear discards a partial frame and a same-cycle last beat.
    terms = {28'h5, 28'h5};
    for (int i = 0; i < 2; i++) send_beat(terms[i], 1'b0);
    clear = 1'b1; in_valid = 1'b1; product = 28'h77; in_last = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("clr_no_valid", 64'(out_valid), 64'd0);
    check("clr_in_ready", 64'(in_ready),  64'd1);
    step();
    check("clr_no_valid2", 64'(out_valid), 64'd0);
    terms = {28'h9};
    send_frame(0);
    check_result("clr");
    check("clr_sum_const", 64'(out_sum), 64'h9);
    // Clear in HOLD leaves the result intact.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_hold_valid", 64'(out_valid), 64'd1);
    check("clr_hold_sum",   64'(out_sum),   64'h9);
    handshake(0);

    // Random frames with gaps and backpressure.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 8);
      terms.delete();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) terms.push_back(64'($urandom_range(0, 15)));
        else terms.push_back(64'($urandom) & 64'hFFFFFFF);
      end
      send_frame(2);
      check_result("rand");
      handshake($urandom_range(0, 3));
    end

    // Reset while holding a result.
    terms = {28'h123, 28'h456};
    send_frame(0);
    check_result("pre_rst");
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    check("rst_hold_sum",   64'(out_sum),   64'd0);
    check("rst_hold_ready", 64'(in_ready),  64'd1);
    step();
    check("rst_hold_ready2", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csam_product_accumulator.md
Name: csam_product_accumulator

Overview:
- Downstream consumer of the 16x12 carry-save array multiplier (csam_multiplier).
- Takes its 28-bit unsigned product one term per accepted beat and accumulates the terms into a wider running sum, forming a dot product.
- A term flagged in_last closes the frame; the final sum, term count and overflow flag are then presented on a valid/ready output port.
- Provides the registered, flow-controlled boundary behind the purely combinational multiplier.

Parameters:
- PROD_W, 28, width of the product input (16 + 12).
- ACC_W, 36, accumulator and result width. Must be >= PROD_W.
- CNT_W, 8, width of the term counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- clear  input  1  synchronous abort: discards the partial frame.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a product beat.
- product  input  PROD_W  unsigned product from the multiplier.
- in_last  input  1  this beat is the final term of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of terms in the frame, saturating.
- out_ovf  output  1  sticky: a carry out of ACC_W occurred in this frame.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=ACCUM; acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=1 in the first cycle after reset deasserts.
- States: ACCUM (collecting terms) and HOLD (result presented).
- in_ready = (state==ACCUM), taken combinationally from the state register. A beat is accepted when in_valid & in_ready.
- ACCUM, accepted beat with in_last=0:
  - acc <= acc + zero-extended product, wrapping modulo 2^ACC_W.
  - ovf <= ovf | carry-out.
  - cnt <= cnt+1, saturating at 2^CNT_W-1.
- ACCUM, accepted beat with in_last=1:
  - out_sum, out_ovf and out_count are loaded with the values including this term.
  - out_valid <= 1; state <= HOLD.
  - Internal acc, cnt and ovf are cleared in the same cycle.
  - Latency: the result is visible the cycle after the last beat.
- HOLD:
  - in_ready=0.
  - out_sum, out_count and out_ovf stay stable while out_valid=1 and out_ready=0.
  - When out_ready=1: out_valid <= 0, state <= ACCUM, and the next beat can be accepted the following cycle.
  - Output registers keep their last values after the handshake; only out_valid drops.
- A single-term frame (in_last on the first beat) produces out_count=1 and out_sum=product.
- ACCUM with no in_valid: acc, cnt and ovf hold.
- clear=1:
  - In ACCUM: acc, cnt and ovf are zeroed and any beat in that cycle is dropped, even one with in_last. No output is produced.
  - In HOLD: no effect; the held result is preserved.
- reset takes priority over clear and over everything else, including in HOLD: the pending result is lost and out_valid goes to 0.
- Product bits are treated as unsigned. Products with X/Z bits are not defined input.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset 3 cycles, then release:
  - During reset: out_valid=0, out_sum=0, in_ready=0 is not required; in_ready=1 the first cycle after release.
- Four beats of product=0xFFEF001 (a=0xFFFF, b=0xFFF), in_last on the 4th, out_ready=1:
  - One cycle later: out_valid=1, out_sum=0x3FFBC004, out_count=4, out_ovf=0.
  - out_valid drops the next cycle.
- Backpressure: frame of {0x10, 0x20, last 0x30} with out_ready=0 for 5 cycles:
  - out_sum=0x60 and out_count=3 held stable; in_ready=0 and in_valid beats are ignored.
  - After out_ready=1, a new frame of {last 0x7} gives out_sum=0x7, out_count=1.
- ACC_W=30 override, five beats of 0xFFEF001:
  - out_sum=0x0FFAB005, out_ovf=1.
  - Next frame {last 0x1}: out_ovf=0.
- Count saturation: 300 beats of product=1, last on the 300th:
  - out_count=255, out_sum=0x12C.
- clear after 2 beats of 0x5, then {last 0x9}:
  - out_sum=0x9, out_count=1.
- reset asserted while in HOLD:
  - out_valid=0 next cycle; state ACCUM.
